shared_data_ram: RTL and testbench

Parametrised single-port data memory shared by `CORES` processor cores through a round-robin arbiter. It is the multicore successor to the single-core data RAM and serves one read or write per clock. Read latency is fixed at one cycle after grant, and each read return is tagged to its requester. It sits between the core array and the data memory, with one request port per core.

---
 rtl/mem_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 57 +++++
 rtl/shared_data_ram.sv | 96 +++++++++
 tb/tb_shared_data_ram.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the multicore memory blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DEPTH = 4096;
    localparam int DEF_CORES = 4;
    localparam int MAX_CORES = 16;

    // Pointer width never collapses to zero bits, so a single requester still has a legal ptr.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping modulo N.
// Latency: grant is combinational (0 cycles); ptr advances at the grant edge.
// Backpressure: losers are not queued; they keep req asserted until granted.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int N  = DEF_CORES,
    localparam int PW = ptr_width(N)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic          hit;
    logic [PW-1:0] g_idx;
    logic [PW-1:0] ptr_nxt;

    // Two passes give the wrap: first the bits at or above ptr, then from bit 0 up.
    always_comb begin
        gnt   = '0;
        hit   = 1'b0;
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i] && (i >= int'(ptr))) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                g_idx  = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i]) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                g_idx  = PW'(i);
            end
        end
    end

    always_comb begin
        ptr_nxt = '0;
        if (int'(g_idx) != N - 1) begin
            ptr_nxt = g_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/shared_data_ram.sv
// Single-port data RAM shared by CORES cores via round-robin arbitration; one access per clock.
// Latency: grant combinational; read data and its one-hot rdValid tag registered 1 cycle after grant.
// Backpressure: non-granted cores hold req/wrEn/addr/dataIn stable; nothing is queued.
module shared_data_ram
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CORES      = DEF_CORES,
    parameter int MEM_INIT   = 0
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            wrEn,
    input  logic [CORES*ADDR_WIDTH-1:0] addr,
    input  logic [CORES*WIDTH-1:0]      dataIn,
    output logic [CORES-1:0]            gnt,
    output logic [CORES-1:0]            rdValid,
    output logic [WIDTH-1:0]            dataOut,
    input  logic                        processDone
);

    localparam int PW = ptr_width(CORES);

    if (CORES < 1 || CORES > MAX_CORES) begin : g_cores_check
        $error("shared_data_ram: CORES out of range 1..16");
    end

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]         arb_ptr;
    logic                  acc_vld;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_dat;
    logic                  in_range;
    logic                  rd_acc;

    // Preload and dump of contents are handled by the simulation harness, not this RTL.
    logic unused_sim;
    assign unused_sim = processDone ^ (MEM_INIT != 0) ^ (|arb_ptr);

    rr_arbiter #(
        .N (CORES)
    ) u_arb (
        .clk  (clk),
        .rstN (rstN),
        .req  (req),
        .gnt  (gnt),
        .ptr  (arb_ptr)
    );

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_dat  = '0;
        for (int i = 0; i < CORES; i++) begin
            if (gnt[i]) begin
                sel_wr   = wrEn[i];
                sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dat  = dataIn[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only a non-power-of-two depth can see addresses past the end of the array.
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (int'(sel_addr) < DEPTH);
    end

    // No access is performed while reset is held, even though gnt still follows req.
    assign acc_vld = rstN && (|gnt);
    assign rd_acc  = acc_vld && !sel_wr;

    always_ff @(posedge clk) begin
        if (acc_vld && sel_wr && in_range) begin
            mem[sel_addr] <= sel_dat;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdValid <= '0;
            dataOut <= '0;
        end else begin
            rdValid <= rd_acc ? gnt : '0;
            if (rd_acc) begin
                dataOut <= in_range ? mem[sel_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_shared_data_ram.sv
module tb_shared_data_ram;

    localparam int W  = 12;
    localparam int AW = 12;
    localparam int C  = 4;

    logic            clk;
    logic            rstN;
    logic [C-1:0]    req;
    logic [C-1:0]    wrEn;
    logic [C*AW-1:0] addr;
    logic [C*W-1:0]  dataIn;
    logic [C-1:0]    gnt;
    logic [C-1:0]    rdValid;
    logic [W-1:0]    dataOut;
    logic            processDone;

    int total = 0;
    int bad   = 0;

    shared_data_ram #(
        .WIDTH      (W),
        .DEPTH      (4096),
        .ADDR_WIDTH (AW),
        .CORES      (C),
        .MEM_INIT   (0)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req),
        .wrEn        (wrEn),
        .addr        (addr),
        .dataIn      (dataIn),
        .gnt         (gnt),
        .rdValid     (rdValid),
        .dataOut     (dataOut),
        .processDone (processDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [W-1:0] d);
        req[i]             = 1'b1;
        wrEn[i]            = wr;
        addr[i*AW +: AW]   = a;
        dataIn[i*W +: W]   = d;
    endtask

    task automatic clr_all();
        req    = '0;
        wrEn   = '0;
        addr   = '0;
        dataIn = '0;
    endtask

    logic [W-1:0] vals [C];
    logic [C-1:0] prev_oh;
    logic [C-1:0] exp_oh;

    initial begin
        processDone = 1'b0;
        rstN = 1'b0;
        clr_all();
        for (int i = 0; i < C; i++) vals[i] = W'(12'h100 + i * 12'h011);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdValid", 32'(rdValid), 32'h0);
        chk("rst_dataOut", 32'(dataOut), 32'h0);
        chk("rst_ptr", 32'(dut.u_arb.ptr), 32'h0);
        chk("rst_gnt_idle", 32'(gnt), 32'h0);
        rstN = 1'b1;

        // Core0 writes 0x0A3 to addr 5, then reads it back
        @(negedge clk);
        set_core(0, 1'b1, 12'd5, 12'h0A3);
        #1 chk("wr5_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("wr5_rdValid", 32'(rdValid), 32'h0);
        chk("wr5_ptr", 32'(dut.u_arb.ptr), 32'h1);
        set_core(0, 1'b0, 12'd5, 12'h000);
        #1 chk("rd5_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("rd5_rdValid", 32'(rdValid), 32'h1);
        chk("rd5_dataOut", 32'(dataOut), 32'h0A3);

        // Core2 writes 0x7FF to addr 100 then reads it on the next cycle
        clr_all();
        set_core(2, 1'b1, 12'd100, 12'h7FF);
        #1 chk("wr100_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        chk("wr100_rdValid", 32'(rdValid), 32'h0);
        set_core(2, 1'b0, 12'd100, 12'h000);
        #1 chk("rd100_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        chk("rd100_rdValid", 32'(rdValid), 32'h4);
        chk("rd100_dataOut", 32'(dataOut), 32'h7FF);
        chk("rd100_ptr", 32'(dut.u_arb.ptr), 32'h3);

        // Preload addr 200+i with vals[i], one core at a time (ptr ends at 0)
        for (int i = 0; i < C; i++) begin
            clr_all();
            set_core(i, 1'b1, AW'(200 + i), vals[i]);
            @(negedge clk);
        end
        chk("preload_ptr", 32'(dut.u_arb.ptr), 32'h0);

        // Full contention: all cores read for 8 cycles, grants 0,1,2,3,0,1,2,3
        clr_all();
        for (int i = 0; i < C; i++) set_core(i, 1'b0, AW'(200 + i), 12'h000);
        prev_oh = '0;
        for (int k = 0; k < 8; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            #1 chk("cont_gnt", 32'(gnt), 32'(exp_oh));
            @(negedge clk);
            chk("cont_rdValid", 32'(rdValid), 32'(exp_oh));
            chk("cont_dataOut", 32'(dataOut), 32'(vals[k % 4]));
            prev_oh = exp_oh;
        end
        clr_all();
        @(negedge clk);
        chk("cont_tail_rdValid", 32'(rdValid), 32'h0);
        chk("cont_tail_hold", 32'(dataOut), 32'(vals[3]));

        // Move ptr to 2, then only cores 0 and 3 request: grant 3, 0, 3
        set_core(1, 1'b1, 12'd300, 12'h055);
        @(negedge clk);
        chk("skip_ptr", 32'(dut.u_arb.ptr), 32'h2);
        clr_all();
        set_core(0, 1'b0, 12'd200, 12'h000);
        set_core(3, 1'b0, 12'd203, 12'h000);
        #1 chk("skip_gnt_a", 32'(gnt), 32'h8);
        @(negedge clk);
        chk("skip_rv_a", 32'(rdValid), 32'h8);
        chk("skip_do_a", 32'(dataOut), 32'(vals[3]));
        #1 chk("skip_gnt_b", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("skip_rv_b", 32'(rdValid), 32'h1);
        chk("skip_do_b", 32'(dataOut), 32'(vals[0]));
        #1 chk("skip_gnt_c", 32'(gnt), 32'h8);
        @(negedge clk);
        chk("skip_rv_c", 32'(rdValid), 32'h8);

        // Reset held across the edge where core1's read would be accepted
        clr_all();
        set_core(1, 1'b0, 12'd100, 12'h000);
        #1 chk("rstmid_gnt", 32'(gnt), 32'h2);
        rstN = 1'b0;
        #1 chk("rstmid_ptr", 32'(dut.u_arb.ptr), 32'h0);
        chk("rstmid_dataOut", 32'(dataOut), 32'h0);
        @(negedge clk);
        chk("rstmid_rv1", 32'(rdValid), 32'h0);
        clr_all();
        rstN = 1'b1;
        @(negedge clk);
        chk("rstmid_rv2", 32'(rdValid), 32'h0);
        chk("rstmid_ptr2", 32'(dut.u_arb.ptr), 32'h0);

        // Memory preserved across reset
        set_core(1, 1'b0, 12'd100, 12'h000);
        @(negedge clk);
        chk("keep100_rv", 32'(rdValid), 32'h2);
        chk("keep100_do", 32'(dataOut), 32'h7FF);
        clr_all();
        set_core(0, 1'b0, 12'd5, 12'h000);
        @(negedge clk);
        chk("keep5_rv", 32'(rdValid), 32'h1);
        chk("keep5_do", 32'(dataOut), 32'h0A3);
        chk("keep5_ptr", 32'(dut.u_arb.ptr), 32'h1);

        // Idle for 10 cycles: nothing moves, dataOut holds
        clr_all();
        for (int k = 0; k < 10; k++) begin
            #1 chk("idle_gnt", 32'(gnt), 32'h0);
            @(negedge clk);
            chk("idle_rv", 32'(rdValid), 32'h0);
            chk("idle_ptr", 32'(dut.u_arb.ptr), 32'h1);
            chk("idle_do", 32'(dataOut), 32'h0A3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
